seq_divider: RTL and testbench

- Sequential unsigned restoring divider: WIDTH_N-bit dividend ÷ WIDTH_D-bit divisor produces a quotient and a remainder.
- It is the inverse of the team's combinational array/Wallace multiplier, and is used for division in the same arithmetic datapath.
- Iterative, one quotient bit per clock, with a start/busy/done handshake.
- Quotient × divisor + remainder reconstructs the dividend, so it can be cross-checked against the multiplier.

---
 rtl/seq_divider.sv | 125 ++++++++++++
 tb/tb_seq_divider.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - synchronous active-high reset, overrides start
//   start     - request; accepted when idle or in the done cycle
//   dividend  - WIDTH_N-bit unsigned dividend, captured on accept
//   divisor   - WIDTH_D-bit unsigned divisor, captured on accept
//   busy      - high while iterating
//   done      - single-cycle pulse; results valid from this cycle
//   quotient  - WIDTH_N-bit quotient (all ones on divide-by-zero)
//   remainder - WIDTH_D-bit remainder (dividend low bits on divide-by-zero)
//   div_zero  - set together with done when the divisor was zero
module seq_divider #(
    parameter int unsigned WIDTH_N = 16,
    parameter int unsigned WIDTH_D = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               div_zero
);

    localparam int unsigned CntW = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH_N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH_D:0]   p_q, p_d;       // extra bit keeps max-value trials from overflowing
    logic [WIDTH_N-1:0] q_q, q_d;
    logic [WIDTH_D-1:0] dvsr_q, dvsr_d;
    logic [WIDTH_N-1:0] quot_q, quot_d;
    logic [WIDTH_D-1:0] rem_q, rem_d;
    logic               dz_q, dz_d;

    logic [WIDTH_D:0]   trial;
    logic [WIDTH_D:0]   diff;
    logic               fits;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        trial = {p_q[WIDTH_D-1:0], q_q[WIDTH_N-1]};
        fits  = (trial >= {1'b0, dvsr_q});
        diff  = trial - {1'b0, dvsr_q};

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    dvsr_d = divisor;
                    q_d    = dividend;
                    p_d    = '0;
                    cnt_d  = '0;
                    if (divisor == '0) begin
                        // No iterations: report the saturated result right away.
                        state_d = StDone;
                        quot_d  = '1;
                        rem_d   = dividend[WIDTH_D-1:0];
                        dz_d    = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                p_d   = fits ? diff : trial;
                q_d   = {q_q[WIDTH_N-2:0], fits};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    quot_d  = q_d;
                    rem_d   = p_d[WIDTH_D-1:0];
                    dz_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: stimulus pushes expected results into a
// scoreboard queue, a monitor pops and compares on every done pulse.
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_divider #(
        .WIDTH_N(16),
        .WIDTH_D(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_zero", 32'(div_zero), 32'(e.z));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // Drive one request; returns 1 time unit after the accepting edge with
    // the operand inputs scrambled so later changes are seen as ignored.
    task automatic issue(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                         input logic [7:0] er, input logic ez, input bit push);
        exp_t e;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        if (push) begin
            e = '{q: eq, r: er, z: ez};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    // k0 edges have already elapsed since the accepting edge.
    task automatic wait_done(input string name, input int k0, input int exp_lat,
                             input int exp_busy);
        int k;
        int nb;
        k  = k0;
        nb = 0;
        while (!done && k < 40) begin
            if (busy) nb++;
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_latency"}, 32'(k), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    endtask

    task automatic idle_gap();
        @(posedge clk);
        #1;
        check("done_single_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        int ndone;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(16'd200, 8'd7, 16'd28, 8'd4, 1'b0, 1'b1);
        wait_done("200div7", 0, 16, 16);
        idle_gap();

        issue(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 1'b1);
        wait_done("65535div255", 0, 16, 16);
        idle_gap();

        issue(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 1'b1);
        wait_done("65535div1", 0, 16, 16);
        idle_gap();

        issue(16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 1'b1);
        wait_done("5div9", 0, 16, 16);
        idle_gap();

        issue(16'd0, 8'd3, 16'd0, 8'd0, 1'b0, 1'b1);
        wait_done("0div3", 0, 16, 16);
        idle_gap();

        issue(16'h04D2, 8'd0, 16'hFFFF, 8'hD2, 1'b1, 1'b1);
        wait_done("div_by_zero", 0, 0, 0);
        idle_gap();

        // Back-to-back with a start pulse mid-run that must be ignored.
        issue(16'd100, 8'd10, 16'd10, 8'd0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 16'd999;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("100div10", 5, 16, 11);
        issue(16'd77, 8'd5, 16'd15, 8'd2, 1'b0, 1'b1);
        check("b2b_busy", 32'(busy), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("quotient_hold", 32'(quotient), 32'd10);
        wait_done("77div5", 8, 16, 8);
        idle_gap();

        // Reset lands on the 8th RUN edge; no done may follow.
        issue(16'd999, 8'd7, 16'd0, 8'd0, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        check("midrst_div_zero", 32'(div_zero), 32'd0);
        rst   = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("no_done_after_rst", 32'(ndone), 32'd0);

        issue(16'd999, 8'd7, 16'd142, 8'd5, 1'b0, 1'b1);
        wait_done("999div7", 0, 16, 16);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
